ear_adc: RTL and testbench

- Audio input path for the tape "ear" signal, the receive-side counterpart of the output mixer/DAC chain.
- Drives the feedback leg of an external RC + comparator loop to form a first-order sigma-delta ADC.
- Decimates the comparator bitstream into 8-bit samples.
- Derives a clean 1-bit ear level for the ULA using a hysteresis threshold and a consecutive-sample filter.

---
 rtl/ear_adc.sv | 134 +++++++++++++
 tb/tb_ear_adc.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/ear_adc.sv
// Tape "ear" input path: first-order sigma-delta feedback loop around an external
// RC + comparator, window decimation to 8-bit samples, and a hysteresis/vote ear level.
module ear_adc #(
  parameter int unsigned LOG2W = 8,
  parameter logic [7:0]  HI    = 8'hA0,
  parameter logic [7:0]  LO    = 8'h60,
  parameter int unsigned FILT  = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       cmp,
  output logic       fb,
  output logic [7:0] sample,
  output logic       strobe,
  output logic       ear
);

  localparam logic [LOG2W-1:0] WIN_LAST = {LOG2W{1'b1}};
  localparam logic [LOG2W-1:0] WIN_ONE  = {{(LOG2W-1){1'b0}}, 1'b1};
  localparam logic [2:0]       FILT_C   = 3'(FILT);

  logic             s1_r;
  logic             s2_r;
  logic             fb_r;
  logic [LOG2W-1:0] win_r;
  logic [LOG2W:0]   acc_r;
  logic [7:0]       sample_r;
  logic             strobe_r;
  logic             ear_r;
  logic [2:0]       vcnt_r;

  logic             last_s;
  logic [LOG2W:0]   total_s;
  logic [8:0]       top_s;
  logic [7:0]       sample_next_s;
  logic             vote_valid_s;
  logic             vote_level_s;
  logic [2:0]       vcnt_inc_s;

  // Only a window of all ones reaches 256 after scaling, so clamping the
  // scaled value equals taking the top bits of the clamped total.
  function automatic logic [7:0] clamp8(input logic [8:0] v);
    if (v[8]) begin
      clamp8 = 8'hFF;
    end else begin
      clamp8 = v[7:0];
    end
  endfunction

  // Window-end detection and end-of-window sample arithmetic
  always_comb begin
    last_s        = (win_r == WIN_LAST);
    total_s       = acc_r + {{LOG2W{1'b0}}, fb_r};
    top_s         = 9'(total_s >> (LOG2W - 8));
    sample_next_s = clamp8(top_s);
  end

  // Classify the current sample against the hysteresis thresholds
  always_comb begin
    vote_valid_s = 1'b0;
    vote_level_s = 1'b0;
    vcnt_inc_s   = vcnt_r + 3'd1;
    if (sample_r >= HI) begin
      vote_valid_s = 1'b1;
      vote_level_s = 1'b1;
    end else if (sample_r <= LO) begin
      vote_valid_s = 1'b1;
      vote_level_s = 1'b0;
    end else begin
      vote_valid_s = 1'b0;
      vote_level_s = 1'b0;
    end
  end

  // Two-flop comparator synchronizer feeding the registered feedback bit
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_r <= 1'b0;
      s2_r <= 1'b0;
      fb_r <= 1'b0;
    end else begin
      s1_r <= cmp;
      s2_r <= s1_r;
      fb_r <= s2_r;
    end
  end

  // Window counter, accumulator and decimated sample register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      win_r    <= {LOG2W{1'b0}};
      acc_r    <= {(LOG2W+1){1'b0}};
      sample_r <= 8'h00;
      strobe_r <= 1'b0;
    end else begin
      win_r <= win_r + WIN_ONE;
      if (last_s) begin
        acc_r    <= {(LOG2W+1){1'b0}};
        sample_r <= sample_next_s;
        strobe_r <= 1'b1;
      end else begin
        acc_r    <= total_s;
        strobe_r <= 1'b0;
      end
    end
  end

  // Consecutive-vote filter; evaluated once per new sample
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ear_r  <= 1'b0;
      vcnt_r <= 3'd0;
    end else if (strobe_r) begin
      if (vote_valid_s && (vote_level_s != ear_r)) begin
        if (vcnt_inc_s >= FILT_C) begin
          ear_r  <= vote_level_s;
          vcnt_r <= 3'd0;
        end else begin
          vcnt_r <= vcnt_inc_s;
        end
      end else begin
        vcnt_r <= 3'd0;
      end
    end else begin
      vcnt_r <= vcnt_r;
    end
  end

  assign fb     = fb_r;
  assign sample = sample_r;
  assign strobe = strobe_r;
  assign ear    = ear_r;

endmodule

// File: tb/tb_ear_adc.sv
// Self-checking bench for ear_adc: window-level model, vector table, random windows,
// and a LOG2W=10 instance for the mid-window reset case.
module tb_ear_adc;

  logic       clock = 1'b0;
  logic       reset8, cmp8, fb8, strobe8, ear8;
  logic [7:0] sample8;
  logic       reset10, cmp10, fb10, strobe10, ear10;
  logic [7:0] sample10;

  always #5 clock = ~clock;

  ear_adc #(.LOG2W(8), .HI(8'hA0), .LO(8'h60), .FILT(2)) u_dut8 (
    .clock(clock), .reset(reset8), .cmp(cmp8), .fb(fb8),
    .sample(sample8), .strobe(strobe8), .ear(ear8)
  );

  ear_adc #(.LOG2W(10), .HI(8'hA0), .LO(8'h60), .FILT(2)) u_dut10 (
    .clock(clock), .reset(reset10), .cmp(cmp10), .fb(fb10),
    .sample(sample10), .strobe(strobe10), .ear(ear10)
  );

  int errors = 0;
  int checks = 0;

  // Behavioural model state: cmp history since reset release, counted in clocks
  bit hist[$];
  int m_k;
  int m_sample;
  bit m_ear;
  int m_run;
  bit m_strobe;
  bit m_fb;

  typedef struct {
    logic [7:0] target;
    logic [7:0] exp_sample;
    logic       exp_ear;
  } vec_t;
  vec_t tab[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @clk %0d: got %0d expected %0d", name, m_k, act, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    m_k = 0; m_sample = 0; m_ear = 1'b0; m_run = 0; m_strobe = 1'b0; m_fb = 1'b0;
  endtask

  // One clock edge: fb is cmp delayed 3 clocks; sample = clamped count of fb ones
  task automatic model_step(input bit c);
    int sum;
    int vote;
    hist.push_back(c);
    m_k++;
    m_fb = (m_k >= 3) ? hist[m_k-3] : 1'b0;
    m_strobe = ((m_k % 256) == 0);
    if (m_strobe) begin
      sum = 0;
      for (int n = m_k - 256; n < m_k; n++)
        if (n >= 3) sum += int'(hist[n-3]);
      m_sample = (sum > 255) ? 255 : sum;
    end
    if ((m_k % 256) == 1 && m_k > 1) begin
      vote = (m_sample >= 160) ? 1 : ((m_sample <= 96) ? 0 : -1);
      if (vote >= 0 && vote != int'(m_ear)) begin
        m_run++;
        if (m_run == 2) begin
          m_ear = bit'(vote);
          m_run = 0;
        end
      end else begin
        m_run = 0;
      end
    end
  endtask

  task automatic tick(input bit c);
    cmp8 = c;
    @(posedge clock);
    model_step(c);
    #1;
    check("fb", fb8, m_fb);
    check("strobe", strobe8, m_strobe);
    check("sample", sample8, m_sample);
    check("ear", ear8, m_ear);
  endtask

  task automatic do_reset8();
    @(posedge clock);
    #1;
    reset8 = 1'b0;
    model_reset();
    #1;
    check("rst_fb", fb8, 0);
    check("rst_sample", sample8, 0);
    check("rst_strobe", strobe8, 0);
    check("rst_ear", ear8, 0);
    repeat (2) @(posedge clock);
    #1;
    reset8 = 1'b1;
  endtask

  task automatic tick10(input bit c);
    cmp10 = c;
    @(posedge clock);
    #1;
  endtask

  task automatic wait_strobe10(input bit c, output int clk);
    clk = -1;
    for (int i = 1; i <= 1100; i++) begin
      tick10(c);
      if (strobe10 === 1'b1) begin
        clk = i;
        break;
      end
    end
  endtask

  // Plan the fb stream per window, then drive cmp 3 clocks ahead of it
  function automatic bit cmp_for(input int c);
    int n;
    int w;
    n = c + 3;
    w = n / 256;
    if (w < 15) return ((n % 256) < int'(tab[w].target));
    return 1'b0;
  endfunction

  initial begin
    #2ms;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int clk10;
    int cnt;
    int p;
    tab[0]  = '{8'h00, 8'h00, 1'b0};
    tab[1]  = '{8'hA0, 8'hA0, 1'b0};
    tab[2]  = '{8'h80, 8'h80, 1'b0};
    tab[3]  = '{8'hA0, 8'hA0, 1'b0};
    tab[4]  = '{8'hA0, 8'hA0, 1'b1};
    tab[5]  = '{8'h61, 8'h61, 1'b1};
    tab[6]  = '{8'h60, 8'h60, 1'b1};
    tab[7]  = '{8'h61, 8'h61, 1'b1};
    tab[8]  = '{8'h60, 8'h60, 1'b1};
    tab[9]  = '{8'h60, 8'h60, 1'b0};
    tab[10] = '{8'hFF, 8'hFF, 1'b0};
    tab[11] = '{8'h9F, 8'h9F, 1'b0};
    tab[12] = '{8'h00, 8'h00, 1'b0};
    tab[13] = '{8'hFF, 8'hFF, 1'b0};
    tab[14] = '{8'hFF, 8'hFF, 1'b1};

    reset8 = 1'b0; cmp8 = 1'b0; reset10 = 1'b0; cmp10 = 1'b0;
    model_reset();

    // Constant cmp=1: 253 then 255, ear rises after the second vote
    do_reset8();
    for (int i = 1; i <= 514; i++) begin
      tick(1'b1);
      if (i == 256) begin
        check("ones_strobe1", strobe8, 1);
        check("ones_sample1", sample8, 253);
      end
      if (i == 512) check("ones_sample2", sample8, 255);
    end
    check("ones_ear", ear8, 1);

    // Constant cmp=0 from reset, then alternating cmp
    do_reset8();
    for (int i = 1; i <= 1024; i++) tick(1'b0);
    check("zeros_fb", fb8, 0);
    check("zeros_sample", sample8, 0);
    check("zeros_ear", ear8, 0);
    for (int i = 0; i < 768; i++) tick(bit'(i & 1));
    check("toggle_sample", sample8, 128);
    check("toggle_ear", ear8, 0);

    // Vector table: one window per record, checked at strobe and after the vote
    do_reset8();
    for (int c = 0; c < 15 * 256 + 2; c++) begin
      tick(cmp_for(c));
      cnt = c + 1;
      if ((cnt % 256) == 0) begin
        check("tab_strobe", strobe8, 1);
        check("tab_sample", sample8, tab[cnt/256-1].exp_sample);
      end
      if ((cnt % 256) == 2 && cnt > 256)
        check("tab_ear", ear8, tab[cnt/256-1].exp_ear);
    end

    // Random density windows against the model
    for (int w = 0; w < 10; w++) begin
      p = $urandom_range(0, 256);
      for (int i = 0; i < 256; i++) tick(($urandom_range(0, 255) < p) ? 1'b1 : 1'b0);
    end

    // LOG2W=10: mid-window reset discards partial window
    cmp10 = 1'b1;
    reset10 = 1'b1;
    for (int i = 0; i < 600; i++) tick10(1'b1);
    reset10 = 1'b0;
    #1;
    check("r10_rst_sample", sample10, 0);
    check("r10_rst_ear", ear10, 0);
    tick10(1'b1);
    reset10 = 1'b1;
    wait_strobe10(1'b1, clk10);
    check("r10_strobe_clk", clk10, 1024);
    check("r10_sample", sample10, 255);
    for (int i = 0; i < 300; i++) tick10(1'b1);
    reset10 = 1'b0;
    tick10(1'b0);
    reset10 = 1'b1;
    wait_strobe10(1'b0, clk10);
    check("r10_zero_clk", clk10, 1024);
    check("r10_zero_sample", sample10, 0);
    check("r10_zero_fb", fb10, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
